// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game controller: state codes, default
// screen/paddle/ball geometry and small arithmetic helpers.
package pong_pkg;

  typedef logic [1:0] game_state_t;

  localparam game_state_t STATE_SERVE     = 2'd0;
  localparam game_state_t STATE_PLAY      = 2'd1;
  localparam game_state_t STATE_POINT     = 2'd2;
  localparam game_state_t STATE_GAME_OVER = 2'd3;

  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_SCREEN_H     = 480;
  localparam int DEF_PADDLE_W     = 10;
  localparam int DEF_PADDLE_H     = 50;
  localparam int DEF_BALL_SIZE    = 8;
  localparam int DEF_PADDLE_STEP  = 4;
  localparam int DEF_BALL_STEP    = 2;
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_PAUSE_FRAMES = 60;

  // Score increment that sticks at the winning score instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    if (value >= limit) begin
      return value;
    end else begin
      return value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/pong_paddle_mover.sv
// One paddle's vertical position: steps up/down once per frame, clamped to
// the visible area, with a recentre command used when a new game starts.
module pong_paddle_mover
  import pong_pkg::*;
#(
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       recentre,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y
);

  localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] Y_CENTRE = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0] STEP     = 11'(PADDLE_STEP);

  logic [9:0]  y_r;
  logic [9:0]  y_next_s;
  logic [10:0] y_wide_s;

  assign y_wide_s = {1'b0, y_r};

  // Next paddle position; opposing or absent buttons hold the paddle.
  always_comb begin
    y_next_s = y_r;
    if (recentre) begin
      y_next_s = 10'(Y_CENTRE);
    end else if (enable && up && !down) begin
      y_next_s = (y_wide_s < STEP) ? 10'd0 : 10'(y_wide_s - STEP);
    end else if (enable && down && !up) begin
      y_next_s = ((y_wide_s + STEP) > Y_MAX) ? 10'(Y_MAX) : 10'(y_wide_s + STEP);
    end else begin
      y_next_s = y_r;
    end
  end

  // Paddle register, advanced only on frame ticks.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      y_r <= 10'(Y_CENTRE);
    end else if (frame_tick) begin
      y_r <= y_next_s;
    end else begin
      y_r <= y_r;
    end
  end

  assign y = y_r;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: paddles, ball motion, scoring and the
// SERVE/PLAY/POINT/GAME_OVER sequence, all advanced once per video frame.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
  parameter int BALL_STEP    = DEF_BALL_STEP,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       serve,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] game_state
);

  localparam logic [10:0] PAD_W    = 11'(PADDLE_W);
  localparam logic [10:0] PAD_H    = 11'(PADDLE_H);
  localparam logic [10:0] BALL_SZ  = 11'(BALL_SIZE);
  localparam logic [10:0] BSTEP    = 11'(BALL_STEP);
  localparam logic [10:0] FACE_R   = 11'(SCREEN_W - PADDLE_W - BALL_SIZE);
  localparam logic [10:0] WALL_R   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_BOT    = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  BALL_X_C = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y_C = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
  localparam logic [7:0]  PAUSE_LAST = 8'(PAUSE_FRAMES - 1);

  game_state_t state_r, state_next_s;
  logic [9:0]  ball_x_r, ball_x_next_s;
  logic [9:0]  ball_y_r, ball_y_next_s;
  logic        dx_right_r, dx_next_s;
  logic        dy_down_r, dy_next_s;
  logic        serve_right_r, serve_right_next_s;
  logic [3:0]  p1_score_r, p1_score_next_s;
  logic [3:0]  p2_score_r, p2_score_next_s;
  logic [7:0]  pause_cnt_r, pause_next_s;

  logic        paddle_en_s;
  logic        paddle_recentre_s;
  logic [10:0] bx_w_s, by_w_s, p1_w_s, p2_w_s;
  logic        hit_p1_s, hit_p2_s, wall_l_s, wall_r_s;
  logic        p1_miss_s, p2_miss_s;

  assign paddle_en_s       = (state_r != STATE_GAME_OVER);
  assign paddle_recentre_s = (state_r == STATE_GAME_OVER) && serve;

  pong_paddle_mover #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .PADDLE_STEP (PADDLE_STEP)
  ) u_p1_paddle (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (paddle_en_s),
    .recentre   (paddle_recentre_s),
    .up         (p1_up),
    .down       (p1_down),
    .y          (p1_y)
  );

  pong_paddle_mover #(
    .SCREEN_H    (SCREEN_H),
    .PADDLE_H    (PADDLE_H),
    .PADDLE_STEP (PADDLE_STEP)
  ) u_p2_paddle (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (paddle_en_s),
    .recentre   (paddle_recentre_s),
    .up         (p2_up),
    .down       (p2_down),
    .y          (p2_y)
  );

  // Collision tests use the paddle positions from before this frame's move.
  assign bx_w_s   = {1'b0, ball_x_r};
  assign by_w_s   = {1'b0, ball_y_r};
  assign p1_w_s   = {1'b0, p1_y};
  assign p2_w_s   = {1'b0, p2_y};
  assign hit_p1_s = (bx_w_s < (PAD_W + BSTEP)) && ((by_w_s + BALL_SZ) > p1_w_s)
                    && (by_w_s < (p1_w_s + PAD_H));
  assign hit_p2_s = ((bx_w_s + BSTEP) > FACE_R) && ((by_w_s + BALL_SZ) > p2_w_s)
                    && (by_w_s < (p2_w_s + PAD_H));
  assign wall_l_s = (bx_w_s < BSTEP);
  assign wall_r_s = ((bx_w_s + BSTEP) > WALL_R);
  assign p1_miss_s = (state_r == STATE_PLAY) && !dx_right_r && !hit_p1_s && wall_l_s;
  assign p2_miss_s = (state_r == STATE_PLAY) && dx_right_r && !hit_p2_s && wall_r_s;

  // Per-frame game update: ball motion, scoring and state sequencing.
  always_comb begin
    state_next_s       = state_r;
    ball_x_next_s      = ball_x_r;
    ball_y_next_s      = ball_y_r;
    dx_next_s          = dx_right_r;
    dy_next_s          = dy_down_r;
    serve_right_next_s = serve_right_r;
    p1_score_next_s    = p1_score_r;
    p2_score_next_s    = p2_score_r;
    pause_next_s       = pause_cnt_r;
    case (state_r)
      STATE_SERVE: begin
        ball_x_next_s = BALL_X_C;
        ball_y_next_s = BALL_Y_C;
        dx_next_s     = serve_right_r;
        if (serve) begin
          state_next_s = STATE_PLAY;
        end else begin
          state_next_s = STATE_SERVE;
        end
      end
      STATE_PLAY: begin
        if (p1_miss_s || p2_miss_s) begin
          ball_x_next_s = BALL_X_C;
          ball_y_next_s = BALL_Y_C;
          pause_next_s  = 8'd0;
          state_next_s  = STATE_POINT;
          if (p1_miss_s) begin
            p2_score_next_s    = sat_inc(p2_score_r, WIN);
            serve_right_next_s = 1'b0;
          end else begin
            p1_score_next_s    = sat_inc(p1_score_r, WIN);
            serve_right_next_s = 1'b1;
          end
        end else begin
          if (dx_right_r) begin
            if (hit_p2_s) begin
              ball_x_next_s = 10'(FACE_R);
              dx_next_s     = 1'b0;
            end else begin
              ball_x_next_s = 10'(bx_w_s + BSTEP);
            end
          end else begin
            if (hit_p1_s) begin
              ball_x_next_s = 10'(PAD_W);
              dx_next_s     = 1'b1;
            end else begin
              ball_x_next_s = 10'(bx_w_s - BSTEP);
            end
          end
          if (dy_down_r) begin
            if ((by_w_s + BSTEP) > Y_BOT) begin
              ball_y_next_s = 10'(Y_BOT);
              dy_next_s     = 1'b0;
            end else begin
              ball_y_next_s = 10'(by_w_s + BSTEP);
            end
          end else begin
            if (by_w_s < BSTEP) begin
              ball_y_next_s = 10'd0;
              dy_next_s     = 1'b1;
            end else begin
              ball_y_next_s = 10'(by_w_s - BSTEP);
            end
          end
        end
      end
      STATE_POINT: begin
        if (pause_cnt_r == PAUSE_LAST) begin
          pause_next_s = 8'd0;
          if ((p1_score_r == WIN) || (p2_score_r == WIN)) begin
            state_next_s = STATE_GAME_OVER;
          end else begin
            state_next_s = STATE_SERVE;
          end
        end else begin
          pause_next_s = pause_cnt_r + 8'd1;
        end
      end
      STATE_GAME_OVER: begin
        if (serve) begin
          state_next_s       = STATE_SERVE;
          ball_x_next_s      = BALL_X_C;
          ball_y_next_s      = BALL_Y_C;
          dx_next_s          = 1'b1;
          dy_next_s          = 1'b1;
          serve_right_next_s = 1'b1;
          p1_score_next_s    = 4'd0;
          p2_score_next_s    = 4'd0;
          pause_next_s       = 8'd0;
        end else begin
          state_next_s = STATE_GAME_OVER;
        end
      end
      default: begin
        state_next_s = STATE_SERVE;
      end
    endcase
  end

  // Game registers: reset wins over frame_tick; idle cycles hold everything.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r       <= STATE_SERVE;
      ball_x_r      <= BALL_X_C;
      ball_y_r      <= BALL_Y_C;
      dx_right_r    <= 1'b1;
      dy_down_r     <= 1'b1;
      serve_right_r <= 1'b1;
      p1_score_r    <= 4'd0;
      p2_score_r    <= 4'd0;
      pause_cnt_r   <= 8'd0;
    end else if (frame_tick) begin
      state_r       <= state_next_s;
      ball_x_r      <= ball_x_next_s;
      ball_y_r      <= ball_y_next_s;
      dx_right_r    <= dx_next_s;
      dy_down_r     <= dy_next_s;
      serve_right_r <= serve_right_next_s;
      p1_score_r    <= p1_score_next_s;
      p2_score_r    <= p2_score_next_s;
      pause_cnt_r   <= pause_next_s;
    end else begin
      state_r       <= state_r;
      ball_x_r      <= ball_x_r;
      ball_y_r      <= ball_y_r;
      dx_right_r    <= dx_right_r;
      dy_down_r     <= dy_down_r;
      serve_right_r <= serve_right_r;
      p1_score_r    <= p1_score_r;
      p2_score_r    <= p2_score_r;
      pause_cnt_r   <= pause_cnt_r;
    end
  end

  assign ball_x     = ball_x_r;
  assign ball_y     = ball_y_r;
  assign p1_score   = p1_score_r;
  assign p2_score   = p2_score_r;
  assign game_state = state_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed opening sequence plus
// randomized play compared every cycle against a behavioural game model.
module tb_pong_game_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset, frame_tick, p1_up, p1_down, p2_up, p2_down, serve;
  logic [9:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] game_state;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the game (plain integers, signed velocities).
  int m_p1y, m_p2y, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_st, m_pause, m_sdir;

  pong_game_ctrl dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .frame_tick (frame_tick),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .serve      (serve),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .game_state (game_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1y = 215; m_p2y = 215; m_bx = 316; m_by = 236;
    m_vx = 1; m_vy = 1; m_s1 = 0; m_s2 = 0; m_st = 0; m_pause = 0; m_sdir = 1;
  endtask

  function automatic int move_paddle(int y, logic up, logic dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 430) ? 430 : y + 4;
    return y;
  endfunction

  function automatic bit overlaps(int by, int py);
    return (by + 8 > py) && (by < py + 50);
  endfunction

  // One clock edge of the game rules as described for the controller.
  task automatic model_step();
    int old1, old2, nbx, nby, scorer;
    if (reset) begin
      model_reset();
    end else if (frame_tick) begin
      old1 = m_p1y;
      old2 = m_p2y;
      if (m_st != 3) begin
        m_p1y = move_paddle(m_p1y, p1_up, p1_down);
        m_p2y = move_paddle(m_p2y, p2_up, p2_down);
      end
      case (m_st)
        0: begin
          m_bx = 316; m_by = 236; m_vx = m_sdir;
          if (serve) m_st = 1;
        end
        1: begin
          scorer = 0; nbx = m_bx; nby = m_by;
          if (m_vx < 0) begin
            if (m_bx < 12 && overlaps(m_by, old1)) begin nbx = 10; m_vx = 1; end
            else if (m_bx < 2) scorer = 2;
            else nbx = m_bx - 2;
          end else begin
            if (m_bx + 2 > 622 && overlaps(m_by, old2)) begin nbx = 622; m_vx = -1; end
            else if (m_bx + 2 > 632) scorer = 1;
            else nbx = m_bx + 2;
          end
          if (m_vy < 0) begin
            if (m_by < 2) begin nby = 0; m_vy = 1; end else nby = m_by - 2;
          end else begin
            if (m_by + 2 > 472) begin nby = 472; m_vy = -1; end else nby = m_by + 2;
          end
          if (scorer != 0) begin
            m_bx = 316; m_by = 236; m_st = 2; m_pause = 0;
            if (scorer == 2) begin m_s2 = (m_s2 >= 9) ? 9 : m_s2 + 1; m_sdir = -1; end
            else begin m_s1 = (m_s1 >= 9) ? 9 : m_s1 + 1; m_sdir = 1; end
          end else begin
            m_bx = nbx; m_by = nby;
          end
        end
        2: begin
          m_pause++;
          if (m_pause == 60) begin
            m_pause = 0;
            m_st = (m_s1 == 9 || m_s2 == 9) ? 3 : 0;
          end
        end
        default: begin
          if (serve) model_reset();
        end
      endcase
    end
  endtask

  task automatic compare_all();
    chk("p1_y", int'(p1_y), m_p1y);
    chk("p2_y", int'(p2_y), m_p2y);
    chk("ball_x", int'(ball_x), m_bx);
    chk("ball_y", int'(ball_y), m_by);
    chk("p1_score", int'(p1_score), m_s1);
    chk("p2_score", int'(p2_score), m_s2);
    chk("game_state", int'(game_state), m_st);
  endtask

  // Inputs are changed only at the falling edge; the model follows each rising edge.
  task automatic step();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    compare_all();
  endtask

  initial begin
    int exp_y;
    bit track, did_point_reset;
    reset = 1'b1; frame_tick = 1'b0; serve = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    did_point_reset = 1'b0;
    step(); step();
    chk("rst_p1_y", int'(p1_y), 215);
    chk("rst_ball_x", int'(ball_x), 316);
    chk("rst_ball_y", int'(ball_y), 236);
    chk("rst_state", int'(game_state), 0);

    reset = 1'b0; frame_tick = 1'b1; p1_up = 1'b1;
    exp_y = 215;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_y -= 4;
      chk("p1_up_step", int'(p1_y), exp_y);
      chk("serve_state_hold", int'(game_state), 0);
      chk("serve_ball_x", int'(ball_x), 316);
    end
    p1_down = 1'b1;
    step();
    chk("p1_both_hold", int'(p1_y), 203);
    p1_up = 1'b0; p1_down = 1'b0; p2_down = 1'b1;
    repeat (100) step();
    chk("p2_clamp_bottom", int'(p2_y), 430);
    p2_down = 1'b0; serve = 1'b1;
    step();
    chk("serve_to_play", int'(game_state), 1);
    serve = 1'b0;
    step();
    chk("first_move_x", int'(ball_x), 318);
    chk("first_move_y", int'(ball_y), 238);
    frame_tick = 1'b0;
    repeat (3) step();
    chk("idle_hold_x", int'(ball_x), 318);

    for (int i = 0; i < 30000; i++) begin
      track = ((i / 700) % 2) == 1;
      frame_tick = ($urandom_range(0, 3) != 0);
      serve = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 14999) == 0);
      if (track) begin
        p1_up = (m_p1y + 20 > m_by); p1_down = (m_p1y + 20 < m_by);
        p2_up = (m_p2y + 20 > m_by); p2_down = (m_p2y + 20 < m_by);
      end else if ($urandom_range(0, 7) == 0) begin
        p1_up = 1'($urandom_range(0, 1)); p1_down = 1'($urandom_range(0, 1));
        p2_up = 1'($urandom_range(0, 1)); p2_down = 1'($urandom_range(0, 1));
      end
      if (!did_point_reset && i > 20000 && m_st == 2) begin
        reset = 1'b1;
        did_point_reset = 1'b1;
        step();
        chk("point_reset_p2_y", int'(p2_y), 215);
        chk("point_reset_ball_x", int'(ball_x), 316);
        chk("point_reset_state", int'(game_state), 0);
        chk("point_reset_score", int'(p1_score) + int'(p2_score), 0);
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
